// File: rtl/jk_pkg.sv
// Shared encodings for the multi-mode JK register: mode selects and the
// direction meaning used by both the counter and the shifter.
package jk_pkg;

  localparam logic [1:0] MODE_JK    = 2'b00;
  localparam logic [1:0] MODE_LOAD  = 2'b01;
  localparam logic [1:0] MODE_COUNT = 2'b10;
  localparam logic [1:0] MODE_SHIFT = 2'b11;

  // One dir pin serves both functions: 1 = count up / shift toward MSB.
  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_LEFT = 1'b1;

endpackage

// File: rtl/jk_cell.sv
// Single JK storage cell with clock enable and a synchronous, active-high
// reset to a per-cell value.
module jk_cell (
  input  logic clk,
  input  logic rst,
  input  logic rst_val,
  input  logic ce,
  input  logic j,
  input  logic k,
  output logic q
);

  // NOTE: state is assigned with <= so every cell samples the pre-edge value
  // of its neighbours; blocking assignments here would create order-dependent
  // shift and count behaviour.
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= rst_val;
    end else if (ce) begin
      case ({j, k})
        2'b01:   q <= 1'b0;
        2'b10:   q <= 1'b1;
        2'b11:   q <= ~q;
        default: q <= q;
      endcase
    end
  end

endmodule

// File: rtl/jk_flex_reg.sv
// WIDTH-bit register of JK cells operating as a per-bit JK register, parallel
// load register, up/down counter or bidirectional shift register.
module jk_flex_reg
  import jk_pkg::*;
#(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             dir,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  input  logic [WIDTH-1:0] d,
  input  logic             si,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qn,
  output logic             so,
  output logic             wrap
);

  logic [WIDTH-1:0] t;
  logic [WIDTH-1:0] nxt;
  logic [WIDTH-1:0] cell_j;
  logic [WIDTH-1:0] cell_k;

  // Toggle enables for a ripple-free synchronous counter: a bit flips when all
  // lower bits are 1 (up) or all are 0 (down).
  always_comb begin
    logic carry;
    carry = 1'b1;
    t     = '0;
    for (int i = 0; i < WIDTH; i++) begin
      t[i]  = carry;
      carry = carry & ((dir == DIR_UP) ? q[i] : ~q[i]);
    end
  end

  assign nxt = (dir == DIR_LEFT) ? {q[WIDTH-2:0], si} : {si, q[WIDTH-1:1]};

  // NOTE: both outputs get a value before the case so no path leaves them
  // unassigned, which would otherwise infer latches.
  always_comb begin
    cell_j = j;
    cell_k = k;
    case (mode)
      MODE_LOAD: begin
        cell_j = d;
        cell_k = ~d;
      end
      MODE_COUNT: begin
        cell_j = t;
        cell_k = t;
      end
      MODE_SHIFT: begin
        cell_j = nxt;
        cell_k = ~nxt;
      end
      default: begin
        cell_j = j;
        cell_k = k;
      end
    endcase
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    jk_cell u_cell (
      .clk    (clk),
      .rst    (rst),
      .rst_val(RST_VAL[i]),
      .ce     (en),
      .j      (cell_j[i]),
      .k      (cell_k[i]),
      .q      (q[i])
    );
  end

  assign qn = ~q;

  always_ff @(posedge clk) begin
    if (rst) begin
      so   <= 1'b0;
      wrap <= 1'b0;
    end else begin
      wrap <= en && (mode == MODE_COUNT) &&
              ((dir == DIR_UP) ? (&q) : ~(|q));
      if (en && (mode == MODE_SHIFT)) begin
        so <= (dir == DIR_LEFT) ? q[WIDTH-1] : q[0];
      end
    end
  end

endmodule

// File: tb/tb_jk_flex_reg.sv
// Scoreboard bench for jk_flex_reg: a behavioural model predicts each edge,
// the expectation is queued and compared one cycle later against the DUT.
module tb_jk_flex_reg;

  localparam int         W       = 8;
  localparam logic [7:0] RST_VAL = 8'hA5;

  logic         clk = 1'b0;
  logic         rst, en, dir, si;
  logic [1:0]   mode;
  logic [W-1:0] j, k, d;
  logic [W-1:0] q, qn;
  logic         so, wrap;

  typedef struct packed {
    logic [W-1:0] q;
    logic         so;
    logic         wrap;
  } exp_t;

  exp_t sb[$];
  exp_t m;
  exp_t got;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  jk_flex_reg #(.WIDTH(W), .RST_VAL(RST_VAL)) dut (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .mode(mode),
    .dir (dir),
    .j   (j),
    .k   (k),
    .d   (d),
    .si  (si),
    .q   (q),
    .qn  (qn),
    .so  (so),
    .wrap(wrap)
  );

  task automatic set_in(input logic r, input logic e, input logic [1:0] md,
                        input logic dr, input logic [W-1:0] jj,
                        input logic [W-1:0] kk, input logic [W-1:0] dd,
                        input logic s);
    rst = r; en = e; mode = md; dir = dr; j = jj; k = kk; d = dd; si = s;
  endtask

  // Predict the next state from the current inputs, queue it, advance one edge.
  task automatic tick();
    exp_t n;
    n = m;
    n.wrap = 1'b0;
    if (rst) begin
      n.q  = RST_VAL;
      n.so = 1'b0;
    end else if (en) begin
      case (mode)
        2'b00: for (int i = 0; i < W; i++)
                 case ({j[i], k[i]})
                   2'b01:   n.q[i] = 1'b0;
                   2'b10:   n.q[i] = 1'b1;
                   2'b11:   n.q[i] = ~m.q[i];
                   default: n.q[i] = m.q[i];
                 endcase
        2'b01: n.q = d;
        2'b10: if (dir) begin
                 n.q = m.q + 8'd1;
                 n.wrap = (m.q == 8'hFF);
               end else begin
                 n.q = m.q - 8'd1;
                 n.wrap = (m.q == 8'h00);
               end
        default: if (dir) begin
                   n.so = m.q[W-1];
                   n.q  = m.q << 1;
                   n.q[0] = si;
                 end else begin
                   n.so = m.q[0];
                   n.q  = m.q >> 1;
                   n.q[W-1] = si;
                 end
      endcase
    end
    m = n;
    sb.push_back(n);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    set_in(1'b1, 1'b1, 2'b10, 1'b1, 8'h00, 8'h00, 8'h00, 1'b0);
    tick();
    set_in(1'b0, 1'b0, 2'b00, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
    got = sb.pop_front();
    checks++;
    if ({q, qn, so, wrap} !== {got.q, ~got.q, got.so, got.wrap}) begin
      errors++;
      $display("FAIL reset_sb: got q=%h qn=%h so=%b wrap=%b want q=%h so=%b wrap=%b",
               q, qn, so, wrap, got.q, got.so, got.wrap);
    end
    checks++;
    if ({q, qn, so, wrap} !== {8'hA5, 8'h5A, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_val: got q=%h qn=%h so=%b wrap=%b want q=a5 qn=5a so=0 wrap=0",
               q, qn, so, wrap);
    end
  endtask

  task automatic test_jk();
    logic [7:0] want [4] = '{8'h00, 8'h0F, 8'hF0, 8'h00};
    for (int s = 0; s < 4; s++) begin
      case (s)
        0: set_in(1'b0, 1'b1, 2'b01, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
        1: set_in(1'b0, 1'b1, 2'b00, 1'b0, 8'h0F, 8'h00, 8'h00, 1'b0);
        2: set_in(1'b0, 1'b1, 2'b00, 1'b0, 8'hFF, 8'hFF, 8'h00, 1'b0);
        default: set_in(1'b0, 1'b1, 2'b00, 1'b0, 8'h00, 8'hF0, 8'h00, 1'b0);
      endcase
      tick();
      got = sb.pop_front();
      checks++;
      if ({q, qn, so, wrap} !== {got.q, ~got.q, got.so, got.wrap}) begin
        errors++;
        $display("FAIL jk_sb step %0d: got q=%h so=%b wrap=%b want q=%h so=%b wrap=%b",
                 s, q, so, wrap, got.q, got.so, got.wrap);
      end
      checks++;
      if (q !== want[s]) begin
        errors++;
        $display("FAIL jk_val step %0d: got q=%h want %h", s, q, want[s]);
      end
    end
  endtask

  task automatic test_count();
    // load FE, up x3 (FF, 00+wrap, 01), down x3 (00, FF+wrap, FE)
    logic [7:0] want_q [7] = '{8'hFE, 8'hFF, 8'h00, 8'h01, 8'h00, 8'hFF, 8'hFE};
    logic       want_w [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    for (int s = 0; s < 7; s++) begin
      if (s == 0) set_in(1'b0, 1'b1, 2'b01, 1'b0, 8'h00, 8'h00, 8'hFE, 1'b0);
      else        set_in(1'b0, 1'b1, 2'b10, (s < 4), 8'h00, 8'h00, 8'h00, 1'b0);
      tick();
      got = sb.pop_front();
      checks++;
      if ({q, qn, so, wrap} !== {got.q, ~got.q, got.so, got.wrap}) begin
        errors++;
        $display("FAIL count_sb step %0d: got q=%h wrap=%b want q=%h wrap=%b",
                 s, q, wrap, got.q, got.wrap);
      end
      checks++;
      if (q !== want_q[s] || wrap !== want_w[s]) begin
        errors++;
        $display("FAIL count_val step %0d: got q=%h wrap=%b want q=%h wrap=%b",
                 s, q, wrap, want_q[s], want_w[s]);
      end
    end
  endtask

  task automatic test_shift();
    logic [7:0] want_q [3] = '{8'h81, 8'h03, 8'h01};
    for (int s = 0; s < 3; s++) begin
      case (s)
        0: set_in(1'b0, 1'b1, 2'b01, 1'b0, 8'h00, 8'h00, 8'h81, 1'b0);
        1: set_in(1'b0, 1'b1, 2'b11, 1'b1, 8'h00, 8'h00, 8'h00, 1'b1);
        default: set_in(1'b0, 1'b1, 2'b11, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
      endcase
      tick();
      got = sb.pop_front();
      checks++;
      if ({q, qn, so, wrap} !== {got.q, ~got.q, got.so, got.wrap}) begin
        errors++;
        $display("FAIL shift_sb step %0d: got q=%h so=%b want q=%h so=%b",
                 s, q, so, got.q, got.so);
      end
      if (s > 0) begin
        checks++;
        if (q !== want_q[s] || so !== 1'b1) begin
          errors++;
          $display("FAIL shift_val step %0d: got q=%h so=%b want q=%h so=1",
                   s, q, so, want_q[s]);
        end
      end
    end
  endtask

  task automatic test_enable();
    for (int s = 0; s < 5; s++) begin
      if (s == 0) set_in(1'b0, 1'b1, 2'b01, 1'b0, 8'h00, 8'h00, 8'h10, 1'b0);
      else        set_in(1'b0, (s == 4), 2'b10, 1'b1, 8'h00, 8'h00, 8'h00, 1'b0);
      tick();
      got = sb.pop_front();
      checks++;
      if ({q, qn, so, wrap} !== {got.q, ~got.q, got.so, got.wrap}) begin
        errors++;
        $display("FAIL enable_sb step %0d: got q=%h wrap=%b want q=%h wrap=%b",
                 s, q, wrap, got.q, got.wrap);
      end
      checks++;
      if (q !== ((s == 4) ? 8'h11 : 8'h10) || wrap !== 1'b0) begin
        errors++;
        $display("FAIL enable_val step %0d: got q=%h wrap=%b want q=%h wrap=0",
                 s, q, wrap, (s == 4) ? 8'h11 : 8'h10);
      end
    end
  endtask

  task automatic test_reset_wrap();
    set_in(1'b0, 1'b1, 2'b01, 1'b0, 8'h00, 8'h00, 8'hFF, 1'b0);
    tick();
    got = sb.pop_front();
    set_in(1'b1, 1'b1, 2'b10, 1'b1, 8'h00, 8'h00, 8'h00, 1'b0);
    tick();
    got = sb.pop_front();
    checks++;
    if ({q, qn, so, wrap} !== {got.q, ~got.q, got.so, got.wrap}) begin
      errors++;
      $display("FAIL reset_wrap_sb: got q=%h wrap=%b want q=%h wrap=%b",
               q, wrap, got.q, got.wrap);
    end
    checks++;
    if (q !== RST_VAL || wrap !== 1'b0 || so !== 1'b0) begin
      errors++;
      $display("FAIL reset_wrap_val: got q=%h so=%b wrap=%b want q=a5 so=0 wrap=0",
               q, so, wrap);
    end
  endtask

  task automatic test_random();
    int bad = 0;
    for (int n = 0; n < 10000; n++) begin
      set_in(($urandom_range(63) == 0), ($urandom_range(7) != 0),
             2'($urandom_range(3)), 1'($urandom_range(1)),
             8'($urandom), 8'($urandom), 8'($urandom), 1'($urandom_range(1)));
      tick();
      got = sb.pop_front();
      checks++;
      if ({q, qn, so, wrap} !== {got.q, ~got.q, got.so, got.wrap}) begin
        errors++;
        bad++;
        if (bad <= 10)
          $display("FAIL random cycle %0d: got q=%h qn=%h so=%b wrap=%b want q=%h so=%b wrap=%b",
                   n, q, qn, so, wrap, got.q, got.so, got.wrap);
      end
    end
  endtask

  initial begin
    set_in(1'b1, 1'b0, 2'b00, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
    test_reset();
    test_jk();
    test_count();
    test_shift();
    test_enable();
    test_reset_wrap();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
